// File: rtl/ex_me_pkg.sv
// Shared field widths, per-lane control layout and op encodings for the EX->ME pipeline stage.
package ex_me_pkg;

   localparam int RD_W    = 5;
   localparam int RFWT_W  = 2;
   localparam int MEMOP_W = 4;
   localparam int BROP_W  = 3;

   typedef enum logic [MEMOP_W-1:0] {
      MEMOP_NONE = 4'h0,
      MEMOP_LB   = 4'h1,
      MEMOP_LH   = 4'h2,
      MEMOP_LW   = 4'h3,
      MEMOP_LBU  = 4'h4,
      MEMOP_LHU  = 4'h5,
      MEMOP_SB   = 4'h8,
      MEMOP_SH   = 4'h9,
      MEMOP_SW   = 4'hA
   } memop_e;

   typedef enum logic [BROP_W-1:0] {
      BROP_NONE = 3'd0,
      BROP_EQ   = 3'd1,
      BROP_NE   = 3'd2,
      BROP_LT   = 3'd3,
      BROP_GE   = 3'd4,
      BROP_LTU  = 3'd5,
      BROP_GEU  = 3'd6,
      BROP_JMP  = 3'd7
   } branchop_e;

   // Control portion of one lane; the XLEN-wide data fields are packed next to it by the stage.
   typedef struct packed {
      logic [RD_W-1:0]    rd;
      logic [RFWT_W-1:0]  rfwt_sel;
      logic [MEMOP_W-1:0] memop;
      logic [BROP_W-1:0]  branchop;
      logic               regwrite;
      logic               zero;
      logic               order;
   } ex_me_lane_t;

   localparam int CTRL_W = $bits(ex_me_lane_t);

endpackage

// File: rtl/ex_me_entry_reg.sv
// One LANES-wide entry register: lane valids plus packed payload, with load enable and valid clear.
module ex_me_entry_reg #(
   parameter int LANES = 2,
   parameter int W     = 32
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 load,
   input  logic                 clear,
   input  logic [LANES-1:0]     load_valid,
   input  logic [LANES*W-1:0]   load_data,
   output logic [LANES-1:0]     valid,
   output logic [LANES*W-1:0]   data
);

   // Clear only drops the valids; payload keeps its stale contents.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         valid <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= '0;
      end else if (load) begin
         valid <= load_valid;
         data  <= load_data;
      end
   end

endmodule

// File: rtl/ex_me_pipe_stage.sv
// EX->ME pipeline stage: valid/ready handshake with optional skid entry, per-lane kill,
// flush, preserved-operand capture and a saturating stall counter.
module ex_me_pipe_stage #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  ACT,
   input  logic                  flush,
   input  logic [LANES-1:0]      kill,
   input  logic [LANES-1:0]      in_valid,
   output logic                  in_ready,
   input  logic [LANES*XLEN-1:0] in_pc,
   input  logic [LANES*XLEN-1:0] in_alu,
   input  logic [LANES*XLEN-1:0] in_bradd,
   input  logic [LANES*XLEN-1:0] in_wtdat,
   input  logic [LANES*XLEN-1:0] in_reg1,
   input  logic [LANES*XLEN-1:0] in_reg2,
   input  logic [LANES*5-1:0]    in_rd,
   input  logic [LANES*2-1:0]    in_rfwt_sel,
   input  logic [LANES*4-1:0]    in_memop,
   input  logic [LANES*3-1:0]    in_branchop,
   input  logic [LANES-1:0]      in_regwrite,
   input  logic [LANES-1:0]      in_zero,
   input  logic [LANES-1:0]      in_order,
   output logic [LANES-1:0]      out_valid,
   input  logic                  out_ready,
   output logic [LANES*XLEN-1:0] out_pc,
   output logic [LANES*XLEN-1:0] out_alu,
   output logic [LANES*XLEN-1:0] out_bradd,
   output logic [LANES*XLEN-1:0] out_wtdat,
   output logic [LANES*5-1:0]    out_rd,
   output logic [LANES*2-1:0]    out_rfwt_sel,
   output logic [LANES*4-1:0]    out_memop,
   output logic [LANES*3-1:0]    out_branchop,
   output logic [LANES-1:0]      out_regwrite,
   output logic [LANES-1:0]      out_zero,
   output logic [LANES-1:0]      out_order,
   output logic [LANES*XLEN-1:0] out_reg1_preserved,
   output logic [LANES*XLEN-1:0] out_reg2_preserved,
   output logic [CNT_W-1:0]      stall_cnt
);

   import ex_me_pkg::*;

   localparam int W = 4*XLEN + CTRL_W;

   logic [LANES-1:0]   in_lane_v;
   logic [LANES*W-1:0] in_data;
   logic [LANES*W-1:0] m_data;
   logic [LANES*W-1:0] m_load_data;
   logic [LANES-1:0]   m_load_valid;
   logic               m_load;
   logic               m_clear;
   logic               m_occ;
   logic               accept;
   logic               accept_live;
   logic               drain;

   // An all-killed group is consumed but never occupies an entry.
   assign in_lane_v   = in_valid & ~kill;
   assign accept      = ACT & (|in_valid) & in_ready & ~flush;
   assign accept_live = accept & (|in_lane_v);
   assign m_occ       = |out_valid;
   assign drain       = m_occ & out_ready & ACT;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      ex_me_lane_t      in_ctrl;
      ex_me_lane_t      out_ctrl;
      logic [XLEN-1:0]  reg1_q;
      logic [XLEN-1:0]  reg2_q;

      assign in_ctrl = '{rd:       in_rd[l*RD_W +: RD_W],
                         rfwt_sel: in_rfwt_sel[l*RFWT_W +: RFWT_W],
                         memop:    in_memop[l*MEMOP_W +: MEMOP_W],
                         branchop: in_branchop[l*BROP_W +: BROP_W],
                         regwrite: in_regwrite[l],
                         zero:     in_zero[l],
                         order:    in_order[l]};

      assign in_data[l*W +: W] = {in_pc[l*XLEN +: XLEN], in_alu[l*XLEN +: XLEN],
                                  in_bradd[l*XLEN +: XLEN], in_wtdat[l*XLEN +: XLEN], in_ctrl};

      assign {out_pc[l*XLEN +: XLEN], out_alu[l*XLEN +: XLEN],
              out_bradd[l*XLEN +: XLEN], out_wtdat[l*XLEN +: XLEN], out_ctrl} = m_data[l*W +: W];

      assign out_rd[l*RD_W +: RD_W]           = out_ctrl.rd;
      assign out_rfwt_sel[l*RFWT_W +: RFWT_W] = out_ctrl.rfwt_sel;
      assign out_memop[l*MEMOP_W +: MEMOP_W]  = out_ctrl.memop;
      assign out_branchop[l*BROP_W +: BROP_W] = out_ctrl.branchop;
      assign out_regwrite[l]                  = out_ctrl.regwrite;
      assign out_zero[l]                      = out_ctrl.zero;
      assign out_order[l]                     = out_ctrl.order;

      // Operands survive flush because accept already excludes flush cycles.
      always_ff @(posedge CLK or negedge RST_n) begin
         if (!RST_n) begin
            reg1_q <= '0;
            reg2_q <= '0;
         end else if (accept && in_lane_v[l]) begin
            reg1_q <= in_reg1[l*XLEN +: XLEN];
            reg2_q <= in_reg2[l*XLEN +: XLEN];
         end
      end

      assign out_reg1_preserved[l*XLEN +: XLEN] = reg1_q;
      assign out_reg2_preserved[l*XLEN +: XLEN] = reg2_q;
   end

   if (SKID != 0) begin : g_skid
      logic [LANES-1:0]   s_valid;
      logic [LANES*W-1:0] s_data;
      logic               s_full;
      logic               m_free;
      logic               s_to_m;
      logic               in_to_m;
      logic               in_to_s;

      // S always refills M before the input may, so younger groups never overtake.
      assign s_full  = |s_valid;
      assign m_free  = ~m_occ | drain;
      assign s_to_m  = s_full & m_free;
      assign in_to_m = accept_live & m_free & ~s_full;
      assign in_to_s = accept_live & ~m_free;

      assign m_load       = s_to_m | in_to_m;
      assign m_load_valid = s_to_m ? s_valid : in_lane_v;
      assign m_load_data  = s_to_m ? s_data  : in_data;
      assign m_clear      = flush | (drain & ~m_load);
      assign in_ready     = ~s_full;

      ex_me_entry_reg #(.LANES(LANES), .W(W)) u_s (
         .CLK        (CLK),
         .RST_n      (RST_n),
         .load       (in_to_s),
         .clear      (flush | s_to_m),
         .load_valid (in_lane_v),
         .load_data  (in_data),
         .valid      (s_valid),
         .data       (s_data)
      );
   end else begin : g_noskid
      assign m_load       = accept_live;
      assign m_load_valid = in_lane_v;
      assign m_load_data  = in_data;
      assign m_clear      = flush | (drain & ~accept_live);
      assign in_ready     = ~m_occ | (out_ready & ACT);
   end

   ex_me_entry_reg #(.LANES(LANES), .W(W)) u_m (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .load       (m_load),
      .clear      (m_clear),
      .load_valid (m_load_valid),
      .load_data  (m_load_data),
      .valid      (out_valid),
      .data       (m_data)
   );

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         stall_cnt <= '0;
      end else if (ACT && m_occ && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ex_me_pipe_stage.sv
// Directed bench for ex_me_pipe_stage: a SKID=1 instance and a SKID=0 instance on shared inputs.
module tb_ex_me_pipe_stage;

   logic        CLK;
   logic        RST_n;
   logic        ACT;
   logic        flush;
   logic [1:0]  kill;
   logic [1:0]  in_valid;
   logic [63:0] in_pc, in_alu, in_bradd, in_wtdat, in_reg1, in_reg2;
   logic [9:0]  in_rd;
   logic [3:0]  in_rfwt_sel;
   logic [7:0]  in_memop;
   logic [5:0]  in_branchop;
   logic [1:0]  in_regwrite, in_zero, in_order;
   logic        out_ready;

   logic        in_ready;
   logic [1:0]  out_valid;
   logic [63:0] out_pc, out_alu, out_bradd, out_wtdat, out_reg1_preserved, out_reg2_preserved;
   logic [9:0]  out_rd;
   logic [3:0]  out_rfwt_sel;
   logic [7:0]  out_memop;
   logic [5:0]  out_branchop;
   logic [1:0]  out_regwrite, out_zero, out_order;
   logic [15:0] stall_cnt;

   logic        in_ready0;
   logic [1:0]  out_valid0;
   logic [63:0] out_pc0, out_alu0, out_bradd0, out_wtdat0, out_reg1_preserved0, out_reg2_preserved0;
   logic [9:0]  out_rd0;
   logic [3:0]  out_rfwt_sel0;
   logic [7:0]  out_memop0;
   logic [5:0]  out_branchop0;
   logic [1:0]  out_regwrite0, out_zero0, out_order0;
   logic [15:0] stall_cnt0;

   int test_count = 0;
   int fail_count = 0;

   ex_me_pipe_stage #(.LANES(2), .XLEN(32), .SKID(1), .CNT_W(16)) dut (
      .CLK(CLK), .RST_n(RST_n), .ACT(ACT), .flush(flush), .kill(kill),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_alu(in_alu), .in_bradd(in_bradd), .in_wtdat(in_wtdat),
      .in_reg1(in_reg1), .in_reg2(in_reg2), .in_rd(in_rd), .in_rfwt_sel(in_rfwt_sel),
      .in_memop(in_memop), .in_branchop(in_branchop), .in_regwrite(in_regwrite),
      .in_zero(in_zero), .in_order(in_order),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_alu(out_alu), .out_bradd(out_bradd), .out_wtdat(out_wtdat),
      .out_rd(out_rd), .out_rfwt_sel(out_rfwt_sel), .out_memop(out_memop),
      .out_branchop(out_branchop), .out_regwrite(out_regwrite), .out_zero(out_zero),
      .out_order(out_order), .out_reg1_preserved(out_reg1_preserved),
      .out_reg2_preserved(out_reg2_preserved), .stall_cnt(stall_cnt)
   );

   ex_me_pipe_stage #(.LANES(2), .XLEN(32), .SKID(0), .CNT_W(16)) dut0 (
      .CLK(CLK), .RST_n(RST_n), .ACT(ACT), .flush(flush), .kill(kill),
      .in_valid(in_valid), .in_ready(in_ready0),
      .in_pc(in_pc), .in_alu(in_alu), .in_bradd(in_bradd), .in_wtdat(in_wtdat),
      .in_reg1(in_reg1), .in_reg2(in_reg2), .in_rd(in_rd), .in_rfwt_sel(in_rfwt_sel),
      .in_memop(in_memop), .in_branchop(in_branchop), .in_regwrite(in_regwrite),
      .in_zero(in_zero), .in_order(in_order),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_pc(out_pc0), .out_alu(out_alu0), .out_bradd(out_bradd0), .out_wtdat(out_wtdat0),
      .out_rd(out_rd0), .out_rfwt_sel(out_rfwt_sel0), .out_memop(out_memop0),
      .out_branchop(out_branchop0), .out_regwrite(out_regwrite0), .out_zero(out_zero0),
      .out_order(out_order0), .out_reg1_preserved(out_reg1_preserved0),
      .out_reg2_preserved(out_reg2_preserved0), .stall_cnt(stall_cnt0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Lane 0 carries the base address, lane 1 base+4; other fields are fixed offsets of it.
   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] k, input logic [31:0] base);
      in_valid    = v;
      kill        = k;
      in_pc       = {base + 32'd4, base};
      in_alu      = {base + 32'h11, base + 32'h10};
      in_bradd    = {base + 32'h84, base + 32'h80};
      in_wtdat    = {~(base + 32'd4), ~base};
      in_reg1     = {32'hA000_0000 + base + 32'd4, 32'hA000_0000 + base};
      in_reg2     = {32'hB000_0000 + base + 32'd4, 32'hB000_0000 + base};
      in_rd       = {base[12:8] + 5'd1, base[12:8]};
      in_rfwt_sel = 4'b0110;
      in_memop    = 8'h2A;
      in_branchop = 6'o31;
      in_regwrite = 2'b11;
      in_zero     = 2'b01;
      in_order    = 2'b10;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_n     = 1'b0;
      ACT       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(2'b00, 2'b00, 32'h0);
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'h1);
      checkOutput("reset_stall", 64'(stall_cnt), 64'h0);
      checkOutput("reset_out_pc", out_pc, 64'h0);
      checkOutput("reset_reg1_pres", out_reg1_preserved, 64'h0);
      RST_n = 1'b1;

      // Basic single group, one-cycle latency.
      out_ready = 1'b1;
      applyStimulus(2'b11, 2'b00, 32'h100);
      tick();
      checkOutput("g1_out_valid", 64'(out_valid), 64'h3);
      checkOutput("g1_out_pc", out_pc, 64'h00000104_00000100);
      checkOutput("g1_out_alu", out_alu, 64'h00000111_00000110);
      checkOutput("g1_out_rd", 64'(out_rd), 64'h041);
      checkOutput("g1_stall", 64'(stall_cnt), 64'h0);
      checkOutput("g1_reg1_pres", out_reg1_preserved, 64'hA0000104_A0000100);
      in_valid = 2'b00;
      tick();
      checkOutput("g1_drained", 64'(out_valid), 64'h0);

      // Backpressure: M and S fill, third group waits, then order on release.
      out_ready = 1'b0;
      applyStimulus(2'b11, 2'b00, 32'h200);
      tick();
      checkOutput("bp_m_pc", out_pc, 64'h00000204_00000200);
      checkOutput("bp_ready_a", 64'(in_ready), 64'h1);
      applyStimulus(2'b11, 2'b00, 32'h300);
      tick();
      checkOutput("bp_ready_b", 64'(in_ready), 64'h0);
      applyStimulus(2'b11, 2'b00, 32'h400);
      tick();
      checkOutput("bp_hold_pc", out_pc, 64'h00000204_00000200);
      checkOutput("bp_ready_c", 64'(in_ready), 64'h0);
      checkOutput("bp_stall", 64'(stall_cnt), 64'h2);
      out_ready = 1'b1;
      tick();
      checkOutput("bp_rel_pc1", out_pc, 64'h00000304_00000300);
      checkOutput("bp_rel_ready", 64'(in_ready), 64'h1);
      tick();
      checkOutput("bp_rel_pc2", out_pc, 64'h00000404_00000400);
      checkOutput("bp_rel_valid2", 64'(out_valid), 64'h3);
      in_valid = 2'b00;
      tick();
      checkOutput("bp_empty", 64'(out_valid), 64'h0);
      checkOutput("bp_stall_hold", 64'(stall_cnt), 64'h2);

      // Per-lane kill and fully killed group.
      applyStimulus(2'b11, 2'b10, 32'h500);
      tick();
      checkOutput("kill10_valid", 64'(out_valid), 64'h1);
      checkOutput("kill10_pc0", 64'(out_pc[31:0]), 64'h500);
      checkOutput("kill10_reg1", out_reg1_preserved, 64'hA0000404_A0000500);
      checkOutput("kill10_reg2", out_reg2_preserved, 64'hB0000404_B0000500);
      applyStimulus(2'b11, 2'b11, 32'h600);
      tick();
      checkOutput("kill11_valid", 64'(out_valid), 64'h0);
      checkOutput("kill11_reg1", out_reg1_preserved, 64'hA0000404_A0000500);

      // Flush with M and S full and input presented.
      out_ready = 1'b0;
      applyStimulus(2'b11, 2'b00, 32'h700);
      tick();
      applyStimulus(2'b11, 2'b00, 32'h800);
      tick();
      checkOutput("fl_pre_ready", 64'(in_ready), 64'h0);
      checkOutput("fl_pre_valid", 64'(out_valid), 64'h3);
      checkOutput("fl_pre_stall", 64'(stall_cnt), 64'h3);
      flush = 1'b1;
      applyStimulus(2'b11, 2'b00, 32'h900);
      tick();
      checkOutput("fl_valid", 64'(out_valid), 64'h0);
      checkOutput("fl_ready", 64'(in_ready), 64'h1);
      checkOutput("fl_reg1", out_reg1_preserved, 64'hA0000804_A0000800);
      checkOutput("fl_stall", 64'(stall_cnt), 64'h4);
      flush     = 1'b0;
      in_valid  = 2'b00;
      out_ready = 1'b1;
      tick();
      checkOutput("fl_s_gone", 64'(out_valid), 64'h0);

      // ACT low blocks accept, advance and counting.
      ACT = 1'b0;
      applyStimulus(2'b11, 2'b00, 32'hA00);
      tick();
      checkOutput("act0_no_accept", 64'(out_valid), 64'h0);
      checkOutput("act0_ready", 64'(in_ready), 64'h1);
      ACT       = 1'b1;
      out_ready = 1'b0;
      tick();
      checkOutput("act1_load_pc", out_pc, 64'h00000A04_00000A00);
      in_valid = 2'b00;
      ACT      = 1'b0;
      tick();
      checkOutput("act0_stall_hold", 64'(stall_cnt), 64'h4);
      out_ready = 1'b1;
      tick();
      checkOutput("act0_no_drain", 64'(out_valid), 64'h3);
      ACT = 1'b1;
      tick();
      checkOutput("act1_drained", 64'(out_valid), 64'h0);

      // Stall counter saturation.
      out_ready = 1'b0;
      applyStimulus(2'b11, 2'b00, 32'hB00);
      tick();
      in_valid = 2'b00;
      repeat (70000) @(posedge CLK);
      #1;
      checkOutput("sat_stall", 64'(stall_cnt), 64'hFFFF);
      checkOutput("sat_pc_held", out_pc, 64'h00000B04_00000B00);

      // Reset in the middle of a held transfer.
      RST_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 64'(out_valid), 64'h0);
      checkOutput("mid_rst_stall", 64'(stall_cnt), 64'h0);
      checkOutput("mid_rst_pc", out_pc, 64'h0);
      checkOutput("mid_rst_ready", 64'(in_ready), 64'h1);
      tick();
      RST_n = 1'b1;

      // SKID=0 instance: back-to-back flow and combinational in_ready.
      out_ready = 1'b1;
      applyStimulus(2'b11, 2'b00, 32'hC00);
      #1;
      checkOutput("s0_ready_empty", 64'(in_ready0), 64'h1);
      tick();
      checkOutput("s0_pc_c", out_pc0, 64'h00000C04_00000C00);
      checkOutput("s0_valid_c", 64'(out_valid0), 64'h3);
      applyStimulus(2'b11, 2'b00, 32'hD00);
      tick();
      checkOutput("s0_pc_d", out_pc0, 64'h00000D04_00000D00);
      applyStimulus(2'b11, 2'b00, 32'hE00);
      tick();
      checkOutput("s0_pc_e", out_pc0, 64'h00000E04_00000E00);
      applyStimulus(2'b11, 2'b00, 32'hF00);
      out_ready = 1'b0;
      #1;
      checkOutput("s0_ready_drop", 64'(in_ready0), 64'h0);
      checkOutput("s1_ready_kept", 64'(in_ready), 64'h1);
      tick();
      checkOutput("s0_pc_held", out_pc0, 64'h00000E04_00000E00);
      checkOutput("s0_stall", 64'(stall_cnt0), 64'h1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
